// File: rtl/instr_mem_loadable_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loadable_pkg
// Description : Shared MIPS definitions for the loadable instruction memory:
//               end-of-program marker, NOP encoding, a few opcode/funct
//               constants and the load FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_loadable_pkg;

    localparam logic [31:0] c_HALT_WORD   = 32'hFFFF_FFFF;
    localparam logic [31:0] c_NOP_WORD    = 32'h0000_0000;

    localparam logic [5:0]  c_OP_RTYPE    = 6'h00;
    localparam logic [5:0]  c_OP_BEQ      = 6'h04;
    localparam logic [5:0]  c_OP_LW       = 6'h23;
    localparam logic [5:0]  c_OP_SW       = 6'h2B;
    localparam logic [5:0]  c_FUNCT_ADD   = 6'h20;
    localparam logic [5:0]  c_FUNCT_SUB   = 6'h22;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } load_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_mem_loadable_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loadable_if
// Description : Fetch port and byte-stream load port of the instruction
//               memory. Names are seen from the memory side: i_* are driven
//               by the master (fetch stage / debug unit), o_* by the memory.
//   i_enable, i_PC                 fetch request (stall when i_enable=0)
//   o_Instruction, o_pc_err        registered fetch result
//   i_load_start/valid/byte        load control and byte stream
//   o_load_ready/done/word_count   load status
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_loadable_if #(
    parameter int NBITS  = 32,
    parameter int BYTE   = 8,
    parameter int ADDR_W = 8
);
    logic              i_enable;
    logic [NBITS-1:0]  i_PC;
    logic [NBITS-1:0]  o_Instruction;
    logic              o_pc_err;
    logic              i_load_start;
    logic              i_load_valid;
    logic [BYTE-1:0]   i_load_byte;
    logic              o_load_ready;
    logic              o_load_done;
    logic [ADDR_W:0]   o_word_count;

    modport master (
        output i_enable, i_PC, i_load_start, i_load_valid, i_load_byte,
        input  o_Instruction, o_pc_err, o_load_ready, o_load_done, o_word_count
    );

    modport slave (
        input  i_enable, i_PC, i_load_start, i_load_valid, i_load_byte,
        output o_Instruction, o_pc_err, o_load_ready, o_load_done, o_word_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loadable_byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loadable_byte_word_packer
// Description : Packs a MSB-first byte stream into NBITS-wide words. The
//               completed word is presented combinationally in the same
//               cycle as its last byte (o_word_valid high for that cycle).
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_clear          drop any partial word (start of a new load)
//   i_byte_valid     accepted byte this cycle
//   i_byte           byte data
//   o_word_valid     o_word is complete this cycle
//   o_word           packed word
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loadable_byte_word_packer #(
    parameter int NBITS = 32,
    parameter int BYTE  = 8
) (
    input  wire logic             i_clk,
    input  wire logic             i_reset,
    input  wire logic             i_clear,
    input  wire logic             i_byte_valid,
    input  wire logic [BYTE-1:0]  i_byte,
    output logic                  o_word_valid,
    output logic [NBITS-1:0]      o_word
);
    localparam int BPW   = NBITS / BYTE;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    // Only the bytes already received need storing; the newest byte is
    // appended combinationally so the word is ready on its last byte.
    logic [NBITS-BYTE-1:0] r_word;
    logic [CNT_W-1:0]      r_byte_cnt;

    assign o_word       = {r_word, i_byte};
    assign o_word_valid = i_byte_valid && (r_byte_cnt == CNT_W'(BPW - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_word     <= '0;
            r_byte_cnt <= '0;
        end else if (i_byte_valid) begin
            r_word     <= o_word[NBITS-BYTE-1:0];
            r_byte_cnt <= o_word_valid ? '0 : r_byte_cnt + CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/instr_mem_loadable.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loadable
// Description : Instruction memory for the MIPS fetch stage, loaded at run
//               time from a byte stream. Loading stops on the HALT word
//               (which is stored) or when the memory is full. Fetch is
//               word-aligned, byte-addressed, 1-cycle registered with stall.
//   i_clk, i_reset   clock, synchronous active-high reset
//   bus              instr_mem_loadable_if slave (fetch + load ports)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loadable
    import instr_mem_loadable_pkg::*;
#(
    parameter int               NBITS     = 32,
    parameter int               CELDAS    = 256,
    parameter int               BYTE      = 8,
    parameter logic [NBITS-1:0] HALT_WORD = NBITS'(c_HALT_WORD)
) (
    input  wire logic            i_clk,
    input  wire logic            i_reset,
    instr_mem_loadable_if.slave  bus
);
    localparam int ADDR_W      = $clog2(CELDAS);
    localparam int BPW         = NBITS / BYTE;
    localparam int c_MEM_BYTES = CELDAS * BPW;

    load_state_t        r_state;
    load_state_t        w_state_nxt;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W:0]    r_word_count;
    logic [NBITS-1:0]   r_mem [CELDAS];
    logic [NBITS-1:0]   r_instr;
    logic               r_pc_err;

    logic               w_load_active;
    logic               w_load_entry;
    logic               w_byte_fire;
    logic               w_word_valid;
    logic [NBITS-1:0]   w_word;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_pc_bad;

    assign w_load_active = (r_state == S_LOAD);
    // A start pulse only counts outside LOAD; it restarts from word 0.
    assign w_load_entry  = bus.i_load_start && !w_load_active;
    assign w_byte_fire   = bus.i_load_valid && w_load_active;

    instr_mem_loadable_byte_word_packer #(
        .NBITS (NBITS),
        .BYTE  (BYTE)
    ) u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_load_entry),
        .i_byte_valid (w_byte_fire),
        .i_byte       (bus.i_load_byte),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.i_load_start) w_state_nxt = S_LOAD;
            S_LOAD: if (w_word_valid &&
                        ((w_word == HALT_WORD) || (r_wr_ptr == ADDR_W'(CELDAS - 1))))
                        w_state_nxt = S_DONE;
            S_DONE: if (bus.i_load_start) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || w_load_entry) begin
            r_wr_ptr     <= '0;
            r_word_count <= '0;
        end else if (w_word_valid) begin
            r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
            r_word_count <= r_word_count + (ADDR_W+1)'(1);
        end
    end

    // Memory contents survive reset so a reset mid-load keeps written words.
    always_ff @(posedge i_clk) begin
        if (w_word_valid) r_mem[r_wr_ptr] <= w_word;
    end

    assign w_idx    = bus.i_PC[ADDR_W+1:2];
    assign w_pc_bad = (bus.i_PC[1:0] != 2'b00) ||
                      ({1'b0, bus.i_PC} >= (NBITS+1)'(c_MEM_BYTES));

    // NOPs are forced while loading so a running pipeline sees no garbage.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_load_active) begin
            r_instr  <= NBITS'(c_NOP_WORD);
            r_pc_err <= 1'b0;
        end else if (bus.i_enable) begin
            if (w_pc_bad) begin
                r_instr  <= NBITS'(c_NOP_WORD);
                r_pc_err <= 1'b1;
            end else begin
                r_instr  <= r_mem[w_idx];
                r_pc_err <= 1'b0;
            end
        end
    end

    assign bus.o_Instruction = r_instr;
    assign bus.o_pc_err      = r_pc_err;
    assign bus.o_load_ready  = w_load_active;
    assign bus.o_load_done   = (r_state == S_DONE);
    assign bus.o_word_count  = r_word_count;
endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loadable.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loadable
// Description : Directed self-checking bench. Instance A uses the default
//               depth (256 words); instance B uses 4 words for the
//               memory-full case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loadable;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    instr_mem_loadable_if #(.NBITS(32), .BYTE(8), .ADDR_W(8)) bus_a ();
    instr_mem_loadable_if #(.NBITS(32), .BYTE(8), .ADDR_W(2)) bus_b ();

    instr_mem_loadable #(.NBITS(32), .CELDAS(256), .BYTE(8)) u_dut_a (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_a)
    );

    instr_mem_loadable #(.NBITS(32), .CELDAS(4), .BYTE(8)) u_dut_b (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        bus_a.i_load_valid = 1'b1;
        bus_a.i_load_byte  = b;
        tick();
        bus_a.i_load_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        bus_b.i_load_valid = 1'b1;
        bus_b.i_load_byte  = b;
        tick();
        bus_b.i_load_valid = 1'b0;
    endtask

    task automatic start_a();
        bus_a.i_load_start = 1'b1;
        tick();
        bus_a.i_load_start = 1'b0;
    endtask

    task automatic fetch_a(input logic [31:0] pc);
        bus_a.i_enable = 1'b1;
        bus_a.i_PC     = pc;
        tick();
    endtask

    task automatic fetch_b(input logic [31:0] pc);
        bus_b.i_enable = 1'b1;
        bus_b.i_PC     = pc;
        tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus_a.i_enable = 1'b0; bus_a.i_PC = '0; bus_a.i_load_start = 1'b0;
        bus_a.i_load_valid = 1'b0; bus_a.i_load_byte = '0;
        bus_b.i_enable = 1'b0; bus_b.i_PC = '0; bus_b.i_load_start = 1'b0;
        bus_b.i_load_valid = 1'b0; bus_b.i_load_byte = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_instr", bus_a.o_Instruction, 32'h0);
        check("rst_err",   32'(bus_a.o_pc_err), 32'h0);
        check("rst_ready", 32'(bus_a.o_load_ready), 32'h0);
        check("rst_done",  32'(bus_a.o_load_done), 32'h0);
        check("rst_count", 32'(bus_a.o_word_count), 32'h0);

        // Test 1: load 8C430002 then HALT
        start_a();
        check("t1_ready", 32'(bus_a.o_load_ready), 32'h1);
        send_a(8'h8C); send_a(8'h43); send_a(8'h00); send_a(8'h02);
        check("t1_count1", 32'(bus_a.o_word_count), 32'h1);
        check("t1_notdone", 32'(bus_a.o_load_done), 32'h0);
        repeat (4) send_a(8'hFF);
        check("t1_done",  32'(bus_a.o_load_done), 32'h1);
        check("t1_ready0", 32'(bus_a.o_load_ready), 32'h0);
        check("t1_count2", 32'(bus_a.o_word_count), 32'h2);

        // Test 2: fetch words 0 and 1
        fetch_a(32'd0);
        check("t2_pc0", bus_a.o_Instruction, 32'h8C43_0002);
        check("t2_pc0_err", 32'(bus_a.o_pc_err), 32'h0);
        fetch_a(32'd4);
        check("t2_pc4", bus_a.o_Instruction, 32'hFFFF_FFFF);
        check("t2_pc4_err", 32'(bus_a.o_pc_err), 32'h0);

        // Test 3: misaligned and out-of-range PCs
        fetch_a(32'd2);
        check("t3_mis_instr", bus_a.o_Instruction, 32'h0);
        check("t3_mis_err",   32'(bus_a.o_pc_err), 32'h1);
        fetch_a(32'd1024);
        check("t3_oor_instr", bus_a.o_Instruction, 32'h0);
        check("t3_oor_err",   32'(bus_a.o_pc_err), 32'h1);
        fetch_a(32'd1020);
        check("t3_last_err",  32'(bus_a.o_pc_err), 32'h0);

        // Test 6a: stall holds output while PC changes
        fetch_a(32'd0);
        bus_a.i_enable = 1'b0;
        bus_a.i_PC = 32'd4;    tick();
        check("t6_stall1", bus_a.o_Instruction, 32'h8C43_0002);
        bus_a.i_PC = 32'd2;    tick();
        check("t6_stall2", bus_a.o_Instruction, 32'h8C43_0002);
        bus_a.i_PC = 32'd1024; tick();
        check("t6_stall3", bus_a.o_Instruction, 32'h8C43_0002);
        check("t6_stall3_err", 32'(bus_a.o_pc_err), 32'h0);
        fetch_a(32'd2);
        bus_a.i_enable = 1'b0;
        bus_a.i_PC = 32'd0;    tick();
        check("t6_stall_err_hold", 32'(bus_a.o_pc_err), 32'h1);

        // Test 5: restart from DONE, 6 bytes, reset mid-load
        fetch_a(32'd0);
        start_a();
        send_a(8'h11);
        check("t5_nop_in_load", bus_a.o_Instruction, 32'h0);
        check("t5_err_in_load", 32'(bus_a.o_pc_err), 32'h0);
        check("t5_count_cleared", 32'(bus_a.o_word_count), 32'h0);
        send_a(8'h22); send_a(8'h33); send_a(8'h44);
        send_a(8'h55); send_a(8'h66);
        check("t5_count1", 32'(bus_a.o_word_count), 32'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_rst_ready", 32'(bus_a.o_load_ready), 32'h0);
        check("t5_rst_done",  32'(bus_a.o_load_done), 32'h0);
        check("t5_rst_count", 32'(bus_a.o_word_count), 32'h0);
        fetch_a(32'd0);
        check("t5_mem0_kept", bus_a.o_Instruction, 32'h1122_3344);
        fetch_a(32'd4);
        check("t5_mem1_kept", bus_a.o_Instruction, 32'hFFFF_FFFF);

        // Test 6b: load_valid in IDLE has no effect
        bus_a.i_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_a(8'hAA);
            tick();
        end
        check("t6_idle_ready", 32'(bus_a.o_load_ready), 32'h0);
        check("t6_idle_count", 32'(bus_a.o_word_count), 32'h0);
        fetch_a(32'd0);
        check("t6_idle_mem0", bus_a.o_Instruction, 32'h1122_3344);

        // Test 5 cont.: restart, start pulse ignored mid-load
        bus_a.i_enable = 1'b0;
        start_a();
        send_a(8'hA1); send_a(8'hB2);
        bus_a.i_load_start = 1'b1; tick(); bus_a.i_load_start = 1'b0;
        send_a(8'hC3); send_a(8'hD4);
        check("t5_re_count1", 32'(bus_a.o_word_count), 32'h1);
        repeat (4) send_a(8'hFF);
        check("t5_re_done",   32'(bus_a.o_load_done), 32'h1);
        check("t5_re_count2", 32'(bus_a.o_word_count), 32'h2);
        fetch_a(32'd0);
        check("t5_re_mem0", bus_a.o_Instruction, 32'hA1B2_C3D4);
        fetch_a(32'd4);
        check("t5_re_mem1", bus_a.o_Instruction, 32'hFFFF_FFFF);

        // Test 4: 4-word memory fills up
        bus_b.i_load_start = 1'b1; tick(); bus_b.i_load_start = 1'b0;
        for (int i = 1; i <= 12; i++) send_b(8'(i));
        check("t4_count3",  32'(bus_b.o_word_count), 32'h3);
        check("t4_notdone", 32'(bus_b.o_load_done), 32'h0);
        for (int i = 13; i <= 16; i++) send_b(8'(i));
        check("t4_done",   32'(bus_b.o_load_done), 32'h1);
        check("t4_count4", 32'(bus_b.o_word_count), 32'h4);
        check("t4_ready0", 32'(bus_b.o_load_ready), 32'h0);
        for (int i = 0; i < 4; i++) send_b(8'h77);
        check("t4_extra_count", 32'(bus_b.o_word_count), 32'h4);
        check("t4_extra_ready", 32'(bus_b.o_load_ready), 32'h0);
        fetch_b(32'd0);
        check("t4_mem0", bus_b.o_Instruction, 32'h0102_0304);
        fetch_b(32'd12);
        check("t4_mem3", bus_b.o_Instruction, 32'h0D0E_0F10);
        check("t4_mem3_err", 32'(bus_b.o_pc_err), 32'h0);
        fetch_b(32'd16);
        check("t4_oor_instr", bus_b.o_Instruction, 32'h0);
        check("t4_oor_err",   32'(bus_b.o_pc_err), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
